// File: rtl/wb_regfile_pkg.sv
// Shared constants for the write-back register file and the pipeline stages
// that use register IDs: the "no register" ID, the field widths and the debug FSM states.
package wb_regfile_pkg;

    localparam int REG_W  = 5;
    localparam int WORD_W = 32;

    localparam logic [REG_W-1:0] RNONE = 5'b11111;

    typedef enum logic [1:0] {
        DBG_IDLE = 2'd0,
        DBG_READ = 2'd1,
        DBG_ACK  = 2'd2
    } dbg_state_t;

endpackage

// File: rtl/regfile_dbg_fsm.sv
// Debug read handshake: IDLE latches the address, READ captures the value,
// ACK pulses the acknowledge for one cycle. The current state is exported.
module regfile_dbg_fsm
    import wb_regfile_pkg::*;
#(
    parameter int DW = WORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic [REG_W-1:0] addr,
    input  logic [DW-1:0]    rd_value,
    output logic [REG_W-1:0] rd_addr,
    output logic             ack,
    output logic [DW-1:0]    data,
    output dbg_state_t       state
);

    // Handshake: a request is taken when req is high in IDLE; ack is high for
    // exactly one cycle, two cycles after the request edge. Holding req high
    // through ACK is not treated as a new request until the FSM is back in IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= DBG_IDLE;
            rd_addr <= '0;
            ack     <= 1'b0;
            data    <= '0;
        end else begin
            case (state)
                DBG_IDLE: begin
                    ack <= 1'b0;
                    if (req) begin
                        rd_addr <= addr;
                        state   <= DBG_READ;
                    end
                end
                DBG_READ: begin
                    data  <= rd_value;
                    ack   <= 1'b1;
                    state <= DBG_ACK;
                end
                DBG_ACK: begin
                    ack   <= 1'b0;
                    state <= DBG_IDLE;
                end
                default: begin
                    ack   <= 1'b0;
                    state <= DBG_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Architectural register file on the write-back side: two W-stage write ports,
// two combinational decode read ports, a debug read port and a write counter.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int NREG = 32,
    parameter int DW   = WORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] W_dstE,
    input  logic [DW-1:0]    W_valE,
    input  logic [REG_W-1:0] W_dstM,
    input  logic [DW-1:0]    W_valM,
    input  logic             W_stall,
    input  logic [REG_W-1:0] d_srcA,
    input  logic [REG_W-1:0] d_srcB,
    output logic [DW-1:0]    d_rvalA,
    output logic [DW-1:0]    d_rvalB,
    input  logic             dbg_req,
    input  logic [REG_W-1:0] dbg_addr,
    output logic             dbg_ack,
    output logic [DW-1:0]    dbg_data,
    output logic [DW-1:0]    wr_count
);

    // Slot RNONE has no storage; reads of it are forced to zero.
    logic [DW-1:0] regs [NREG-1];

    logic             we_e;
    logic             we_m;
    logic [1:0]       n_wr;
    logic [REG_W-1:0] dbg_rd_addr;
    logic [DW-1:0]    dbg_rd_value;
    dbg_state_t       dbg_state;

    // On a same-register collision the load result (M) wins, so E is dropped.
    assign we_e = !W_stall && (W_dstE != RNONE) && (W_dstE != W_dstM);
    assign we_m = !W_stall && (W_dstM != RNONE);
    assign n_wr = {1'b0, we_e} + {1'b0, we_m};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG - 1; i++) begin
                regs[i] <= '0;
            end
            wr_count <= '0;
        end else begin
            if (we_e) begin
                regs[W_dstE] <= W_valE;
            end
            if (we_m) begin
                regs[W_dstM] <= W_valM;
            end
            wr_count <= wr_count + DW'(n_wr);
        end
    end

    assign d_rvalA = (d_srcA == RNONE) ? '0 : regs[d_srcA];
    assign d_rvalB = (d_srcB == RNONE) ? '0 : regs[d_srcB];

    // The debug capture sees writes committing at the same edge, so it reads
    // through the write ports; the mux only matters while the FSM is in READ.
    always_comb begin
        dbg_rd_value = '0;
        if (dbg_state == DBG_READ && dbg_rd_addr != RNONE) begin
            if (we_m && W_dstM == dbg_rd_addr) begin
                dbg_rd_value = W_valM;
            end else if (we_e && W_dstE == dbg_rd_addr) begin
                dbg_rd_value = W_valE;
            end else begin
                dbg_rd_value = regs[dbg_rd_addr];
            end
        end
    end

    regfile_dbg_fsm #(
        .DW(DW)
    ) u_dbg (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (dbg_req),
        .addr     (dbg_addr),
        .rd_value (dbg_rd_value),
        .rd_addr  (dbg_rd_addr),
        .ack      (dbg_ack),
        .data     (dbg_data),
        .state    (dbg_state)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: a cycle-level reference model of the register
// file and debug port, checked every cycle, plus hand-computed literal checks.
module tb_wb_regfile;
    import wb_regfile_pkg::*;

    logic             clk;
    logic             rst_n;
    logic [REG_W-1:0] W_dstE;
    logic [31:0]      W_valE;
    logic [REG_W-1:0] W_dstM;
    logic [31:0]      W_valM;
    logic             W_stall;
    logic [REG_W-1:0] d_srcA;
    logic [REG_W-1:0] d_srcB;
    logic [31:0]      d_rvalA;
    logic [31:0]      d_rvalB;
    logic             dbg_req;
    logic [REG_W-1:0] dbg_addr;
    logic             dbg_ack;
    logic [31:0]      dbg_data;
    logic [31:0]      wr_count;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    wb_regfile #(.NREG(32), .DW(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .W_dstE   (W_dstE),
        .W_valE   (W_valE),
        .W_dstM   (W_dstM),
        .W_valM   (W_valM),
        .W_stall  (W_stall),
        .d_srcA   (d_srcA),
        .d_srcB   (d_srcB),
        .d_rvalA  (d_rvalA),
        .d_rvalB  (d_rvalB),
        .dbg_req  (dbg_req),
        .dbg_addr (dbg_addr),
        .dbg_ack  (dbg_ack),
        .dbg_data (dbg_data),
        .wr_count (wr_count)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0]      m_regs [32];
    logic [31:0]      m_count;
    logic             m_valid = 1'b0;
    int               m_cyc = 0;
    int               m_accept_ok_at = 0;
    int               m_capture_edge = -1;
    logic [REG_W-1:0] m_pend_addr;
    logic             m_ack;
    logic [31:0]      m_data;

    function automatic logic [31:0] m_read(input logic [REG_W-1:0] a);
        return (a == RNONE) ? 32'h0 : m_regs[a];
    endfunction

    always @(posedge clk) begin
        int n;
        m_cyc++;
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_count        = 32'h0;
            m_ack          = 1'b0;
            m_data         = 32'h0;
            m_capture_edge = -1;
            m_accept_ok_at = m_cyc + 1;
            m_valid        = 1'b1;
        end else begin
            if (!W_stall) begin
                n = 0;
                if (W_dstE != RNONE) begin m_regs[W_dstE] = W_valE; n++; end
                if (W_dstM != RNONE) begin m_regs[W_dstM] = W_valM; n++; end
                if (W_dstE == W_dstM && W_dstE != RNONE) n--;
                m_count = m_count + 32'(n);
            end
            m_ack = 1'b0;
            if (m_cyc == m_capture_edge) begin
                m_data         = m_read(m_pend_addr);
                m_ack          = 1'b1;
                m_capture_edge = -1;
            end
            if (m_capture_edge == -1 && dbg_req && m_cyc >= m_accept_ok_at) begin
                m_pend_addr    = dbg_addr;
                m_capture_edge = m_cyc + 1;
                m_accept_ok_at = m_cyc + 3;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc_rvalA", d_rvalA, m_read(d_srcA));
            check("cyc_rvalB", d_rvalB, m_read(d_srcB));
            check("cyc_wr_count", wr_count, m_count);
            check("cyc_dbg_ack", {31'h0, dbg_ack}, {31'h0, m_ack});
            check("cyc_dbg_data", dbg_data, m_data);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic no_write();
        W_dstE = RNONE; W_valE = 32'h0;
        W_dstM = RNONE; W_valM = 32'h0;
        W_stall = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n = 1'b0; no_write();
        d_srcA = 5'd0; d_srcB = 5'd0;
        dbg_req = 1'b0; dbg_addr = 5'd0;
        step(); step();

        // 1: write something, then reset with a write pending
        rst_n = 1'b1;
        W_dstE = 5'd5; W_valE = 32'hDEAD_BEEF; W_dstM = 5'd1; W_valM = 32'h1234_5678;
        step();
        rst_n = 1'b0; W_dstE = 5'd6; W_valE = 32'hCAFE;
        step(); step();
        rst_n = 1'b1; no_write();
        d_srcA = 5'd5; d_srcB = 5'd1; #1;
        check("rst_reg5", d_rvalA, 32'h0);
        check("rst_reg1", d_rvalB, 32'h0);
        check("rst_count", wr_count, 32'h0);

        // 2: single E write, visible only after the edge; RNONE writes nothing
        W_dstE = 5'd3; W_valE = 32'h11; d_srcA = 5'd3; #1;
        check("pre_edge_reg3", d_rvalA, 32'h0);
        step();
        no_write();
        check("post_edge_reg3", d_rvalA, 32'h11);
        check("count_1", wr_count, 32'd1);
        W_dstE = RNONE; W_valE = 32'h77;
        step();
        no_write();
        check("rnone_reg3", d_rvalA, 32'h11);
        check("rnone_count", wr_count, 32'd1);

        // 3: collision M wins and counts once; distinct pair counts twice
        W_dstE = 5'd7; W_valE = 32'hAA; W_dstM = 5'd7; W_valM = 32'hBB;
        step();
        no_write(); d_srcA = 5'd7; #1;
        check("collide_reg7", d_rvalA, 32'hBB);
        check("collide_count", wr_count, 32'd2);
        W_dstE = 5'd8; W_valE = 32'h88; W_dstM = 5'd9; W_valM = 32'h99;
        step();
        no_write(); d_srcA = 5'd8; d_srcB = 5'd9; #1;
        check("pair_reg8", d_rvalA, 32'h88);
        check("pair_reg9", d_rvalB, 32'h99);
        check("pair_count", wr_count, 32'd4);

        // 4: stall suppresses writes; RNONE reads are zero; top slot 30
        W_stall = 1'b1; W_dstE = 5'd4; W_valE = 32'h55; W_dstM = 5'd9; W_valM = 32'h1;
        step();
        no_write(); d_srcA = 5'd4; d_srcB = 5'd9; #1;
        check("stall_reg4", d_rvalA, 32'h0);
        check("stall_reg9", d_rvalB, 32'h99);
        check("stall_count", wr_count, 32'd4);
        d_srcA = RNONE; d_srcB = RNONE; #1;
        check("rnone_readA", d_rvalA, 32'h0);
        check("rnone_readB", d_rvalB, 32'h0);
        W_dstM = 5'd30; W_valM = 32'hFFFF_FFFF;
        step();
        no_write(); d_srcA = 5'd30; #1;
        check("reg30", d_rvalA, 32'hFFFF_FFFF);
        check("reg30_count", wr_count, 32'd5);

        // 5: debug reads, held request spacing, write at the READ edge
        W_dstE = 5'd10; W_valE = 32'h1234;
        step();
        no_write();
        dbg_req = 1'b1; dbg_addr = 5'd10;
        step();
        check("dbg_read_noack", {31'h0, dbg_ack}, 32'h0);
        step();
        check("dbg_ack1", {31'h0, dbg_ack}, 32'h1);
        check("dbg_data1", dbg_data, 32'h1234);
        step();
        check("dbg_ack_drop", {31'h0, dbg_ack}, 32'h0);
        step();
        check("dbg_held_gap", {31'h0, dbg_ack}, 32'h0);
        step();
        check("dbg_ack2", {31'h0, dbg_ack}, 32'h1);
        check("dbg_data2", dbg_data, 32'h1234);
        dbg_req = 1'b0;
        step();
        dbg_req = 1'b1; dbg_addr = 5'd10;
        step();
        dbg_req = 1'b0;
        W_dstM = 5'd10; W_valM = 32'h9;
        step();
        no_write();
        check("dbg_ack3", {31'h0, dbg_ack}, 32'h1);
        check("dbg_bypass_data", dbg_data, 32'h9);
        check("dbg_bypass_count", wr_count, 32'd7);
        step();

        // 6: reset during READ aborts the read; FSM accepts right after release
        dbg_req = 1'b1; dbg_addr = 5'd10;
        step();
        rst_n = 1'b0; dbg_req = 1'b0;
        step();
        check("abort_ack", {31'h0, dbg_ack}, 32'h0);
        check("abort_data", dbg_data, 32'h0);
        rst_n = 1'b1; dbg_req = 1'b1; dbg_addr = 5'd10;
        step();
        dbg_req = 1'b0;
        check("post_rst_noack", {31'h0, dbg_ack}, 32'h0);
        step();
        check("post_rst_ack", {31'h0, dbg_ack}, 32'h1);
        check("post_rst_data", dbg_data, 32'h0);
        step(); step();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
